// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//   Nibble-serial add/subtract controller. A wide operand pair is accepted
//   over a valid/ready handshake and fed one nibble per clock, LSB first,
//   through a single time-shared AddSub4Bit slice. The inter-nibble carry
//   is kept in a register. The wide result, the final carry and the signed
//   overflow are returned over a second valid/ready handshake.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand request
//   in_ready   : high only while idle
//   a, b       : W-bit operands (W = 4*NIBBLES)
//   ci         : carry in (add) / extra borrow (sub)
//   sub        : 1 = a-b-ci, 0 = a+b+ci
//   out_valid  : result valid, held until accepted
//   out_ready  : consumer accept
//   s          : W-bit result, modulo 2^W
//   co         : carry out of bit W-1 (sub: 1 = no borrow)
//   ovf        : two's-complement overflow

// 4-bit add/sub slice. It inverts b and the carry input when sub=1, so a
// raw carry fed back as (cout ^ sub) chains correctly across nibbles.
module AddSub4Bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] sum;

    always_comb begin
        sum = {1'b0, a} + {1'b0, b ^ {4{sub}}} + {4'b0000, cin ^ sub};
    end

    assign s    = sum[3:0];
    assign cout = sum[4];
endmodule

module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co,
    output logic                   ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          ci_q, ci_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  s_q, s_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    sl_a, sl_b, sl_s;
    logic          sl_cin, sl_co;

    // Slice input selection: nibble idx of the latched operands. The first
    // nibble takes the external carry/borrow; later nibbles take the stored
    // raw carry pre-inverted for sub, since the slice inverts it again.
    always_comb begin
        sl_a   = a_q[{idx_q, 2'b00} +: 4];
        sl_b   = b_q[{idx_q, 2'b00} +: 4];
        sl_cin = (idx_q == '0) ? ci_q : (carry_q ^ sub_q);
    end

    AddSub4Bit u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (sl_cin),
        .sub  (sub_q),
        .s    (sl_s),
        .cout (sl_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            sub_q   <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            sub_q   <= sub_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        sub_d   = sub_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    ci_d    = ci;
                    sub_d   = sub;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[{idx_q, 2'b00} +: 4] = sl_s;
                carry_d = sl_co;
                if (idx_q == LAST) begin
                    co_d    = sl_co;
                    // Overflow: operands (b as seen by the adder) agree in
                    // sign but the top nibble's sum sign differs.
                    ovf_d   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (sl_s[3] != a_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-width instance (NIBBLES = 4)
    logic        rst_n, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
    logic [15:0] a, b, s;

    // Narrow instance (NIBBLES = 2)
    logic        rst_n2, in_valid2, in_ready2, ci2, sub2, out_valid2, out_ready2, co2, ovf2;
    logic [7:0]  a2, b2, s2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    nibble_serial_addsub #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf)
    );

    nibble_serial_addsub #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .ci(ci2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .s(s2), .co(co2), .ovf(ovf2)
    );

    // Reference: plain integer arithmetic on the mathematical values.
    // Result is reduced modulo 2^w; carry is "sum reached 2^w" for add and
    // "difference non-negative" for sub; overflow is the signed true result
    // falling outside the w-bit two's-complement range.
    function automatic void ref_model(input int w, input longint av, input longint bv,
                                      input int civ, input int subv,
                                      output longint s_e, output logic co_e,
                                      output logic ovf_e);
        longint m, res, sa, sb, tr;
        m = longint'(1) << w;
        if (subv != 0) begin
            res  = av - bv - civ;
            co_e = (res >= 0);
        end else begin
            res  = av + bv + civ;
            co_e = (res >= m);
        end
        s_e   = ((res % m) + m) % m;
        sa    = (av >= m / 2) ? av - m : av;
        sb    = (bv >= m / 2) ? bv - m : bv;
        tr    = (subv != 0) ? sa - sb - civ : sa + sb + civ;
        ovf_e = (tr < -(m / 2)) || (tr >= m / 2);
    endfunction

    // Drives one operation on the 16-bit instance and returns what it saw.
    // Operands are scrambled right after acceptance.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic civ, input logic subv,
                         output logic [17:0] res, output int lat);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        res = {s, co, ovf};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_n2 = 1'b0;
        #12;
        total_cnt++;
        if ({in_ready, out_valid, s, co, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            $display("FAIL reset_state: got rdy=%b vld=%b s=%h co=%b ovf=%b, need rdy=1 vld=0 s=0000 co=0 ovf=0",
                     in_ready, out_valid, s, co, ovf);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1; rst_n2 = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({in_ready, out_valid} !== 2'b10) begin
            $display("FAIL reset_release: got rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
        end else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [15:0] ta  [7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010, 16'h00FF};
        logic [15:0] tb_ [7] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0001, 16'h0000};
        logic        tci [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        tsb [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [17:0] te  [7] = '{{16'h2233, 2'b00}, {16'h0000, 2'b10}, {16'h8000, 2'b01},
                                 {16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}, {16'h000E, 2'b10},
                                 {16'h0100, 2'b00}};
        logic [17:0] res;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(ta[i], tb_[i], tci[i], tsb[i], res, lat);
            total_cnt++;
            if (res !== te[i]) begin
                $display("FAIL directed_%0d: got s=%h co=%b ovf=%b, need s=%h co=%b ovf=%b",
                         i, res[17:2], res[1], res[0], te[i][17:2], te[i][1], te[i][0]);
            end else pass_cnt++;
            total_cnt++;
            if (lat !== 4) begin
                $display("FAIL latency_%0d: got %0d cycles, need 4", i, lat);
            end else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [15:0] av, bv;
        logic        civ, subv, co_e, ovf_e;
        longint      s_e;
        logic [17:0] res;
        int          lat;
        for (int i = 0; i < 24; i++) begin
            av = 16'($urandom); bv = 16'($urandom);
            civ = 1'($urandom); subv = 1'($urandom);
            if (i % 4 == 0) bv = ~av;
            ref_model(16, longint'(av), longint'(bv), int'(civ), int'(subv), s_e, co_e, ovf_e);
            do_op(av, bv, civ, subv, res, lat);
            total_cnt++;
            if (res !== {16'(s_e), co_e, ovf_e} || lat !== 4) begin
                $display("FAIL random_%0d: a=%h b=%h ci=%b sub=%b got s=%h co=%b ovf=%b lat=%0d, need s=%h co=%b ovf=%b lat=4",
                         i, av, bv, civ, subv, res[17:2], res[1], res[0], lat, 16'(s_e), co_e, ovf_e);
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        longint      s_e;
        logic        co_e, ovf_e;
        int          w;
        ref_model(16, 64'h9ABC, 64'h1357, 1, 1, s_e, co_e, ovf_e);
        a = 16'h9ABC; b = 16'h1357; ci = 1'b1; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if ({out_valid, s, co, ovf} !== {1'b1, 16'(s_e), co_e, ovf_e}) begin
                $display("FAIL hold_%0d: got vld=%b s=%h co=%b ovf=%b, need vld=1 s=%h co=%b ovf=%b",
                         c, out_valid, s, co, ovf, 16'(s_e), co_e, ovf_e);
            end else pass_cnt++;
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b01) begin
            $display("FAIL release: got vld=%b rdy=%b, need vld=0 rdy=1", out_valid, in_ready);
        end else pass_cnt++;
    endtask

    task automatic test_ignore_in_valid();
        int w;
        a = 16'h4321; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (in_ready !== 1'b0) begin
            $display("FAIL busy_ready: got in_ready=%b, need 0", in_ready);
        end else pass_cnt++;
        a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 40) begin
            @(posedge clk); #1; w++;
        end
        total_cnt++;
        if ({out_valid, s, co, ovf} !== {1'b1, 16'h5432, 2'b00}) begin
            $display("FAIL ignore_in_valid: got vld=%b s=%h co=%b ovf=%b, need vld=1 s=5432 co=0 ovf=0",
                     out_valid, s, co, ovf);
        end else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [17:0] res;
        int          lat;
        a = 16'h1111; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready, out_valid, s, co, ovf} !== {1'b1, 1'b0, 16'h0000, 2'b00}) begin
            $display("FAIL reset_mid_run: got rdy=%b vld=%b s=%h co=%b ovf=%b, need rdy=1 vld=0 s=0000 co=0 ovf=0",
                     in_ready, out_valid, s, co, ovf);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({in_ready, out_valid} !== 2'b10) begin
                $display("FAIL reset_discard_%0d: got rdy=%b vld=%b, need rdy=1 vld=0", c, in_ready, out_valid);
            end else pass_cnt++;
        end
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, res, lat);
        total_cnt++;
        if (res !== {16'h0002, 2'b00} || lat !== 4) begin
            $display("FAIL after_reset_op: got s=%h co=%b ovf=%b lat=%0d, need s=0002 co=0 ovf=0 lat=4",
                     res[17:2], res[1], res[0], lat);
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [17:0] expq[$];
        logic [17:0] exp_r;
        longint      s_e;
        logic        co_e, ovf_e, acc, fin;
        int          accepted, checked, last_acc;
        accepted = 0; checked = 0; last_acc = 0;
        out_ready = 1'b1;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        in_valid = 1'b1;
        for (int c = 0; c < 200 && checked < 5; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            fin = out_valid && out_ready;
            if (fin) begin
                exp_r = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
                total_cnt++;
                if ({s, co, ovf} !== exp_r) begin
                    $display("FAIL b2b_result_%0d: got s=%h co=%b ovf=%b, need s=%h co=%b ovf=%b",
                             checked, s, co, ovf, exp_r[17:2], exp_r[1], exp_r[0]);
                end else pass_cnt++;
                checked++;
            end
            if (acc) begin
                ref_model(16, longint'(a), longint'(b), int'(ci), int'(sub), s_e, co_e, ovf_e);
                expq.push_back({16'(s_e), co_e, ovf_e});
                if (accepted > 0) begin
                    total_cnt++;
                    if (c - last_acc !== 6) begin
                        $display("FAIL b2b_interval_%0d: got %0d cycles, need 6", accepted, c - last_acc);
                    end else pass_cnt++;
                end
                last_acc = c;
                accepted++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (accepted < 5) begin
                    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (checked !== 5) begin
            $display("FAIL b2b_count: got %0d results, need 5", checked);
        end else pass_cnt++;
    endtask

    task automatic test_nibbles2();
        logic [7:0]  av, bv;
        logic        civ, subv, co_e, ovf_e;
        longint      s_e;
        int          lat;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                av = 8'hFF; bv = 8'h01; civ = 1'b0; subv = 1'b0;
            end else begin
                av = 8'($urandom); bv = 8'($urandom); civ = 1'($urandom); subv = 1'($urandom);
            end
            ref_model(8, longint'(av), longint'(bv), int'(civ), int'(subv), s_e, co_e, ovf_e);
            a2 = av; b2 = bv; ci2 = civ; sub2 = subv; in_valid2 = 1'b1;
            @(posedge clk); #1;
            in_valid2 = 1'b0;
            lat = 0;
            while (out_valid2 !== 1'b1 && lat < 40) begin
                @(posedge clk); #1; lat++;
            end
            total_cnt++;
            if ({s2, co2, ovf2} !== {8'(s_e), co_e, ovf_e} || lat !== 2) begin
                $display("FAIL n2_%0d: a=%h b=%h ci=%b sub=%b got s=%h co=%b ovf=%b lat=%0d, need s=%h co=%b ovf=%b lat=2",
                         i, av, bv, civ, subv, s2, co2, ovf2, lat, 8'(s_e), co_e, ovf_e);
            end else pass_cnt++;
            out_ready2 = 1'b1;
            @(posedge clk); #1;
            out_ready2 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        rst_n2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
        a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid_run();
        test_back_to_back();
        test_nibbles2();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Multi-cycle, nibble-serial add/subtract controller that sits directly upstream of the 4-bit add/sub slice `AddSub4Bit` and drives it. The block accepts wide operands through a valid/ready handshake. It feeds the slice one nibble per clock, LSB first, and chains the carry through a register. It returns the wide result, carry-out and signed overflow through a second valid/ready handshake. One slice instance is time-shared, so area is traded for NIBBLES cycles of latency.

## Interface
- NIBBLES, 4, number of 4-bit nibbles per operand (≥2); W = 4*NIBBLES.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  W  operand A.
- b  in  W  operand B.
- ci  in  1  carry/borrow in.
- sub  in  1  operation select: 1 computes a−b−ci, 0 computes a+b+ci.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accept.
- s  out  W  result, modulo 2^W.
- co  out  1  final carry; for sub, 1 means no borrow.
- ovf  out  1  two's-complement overflow.

## Operation
- Reset is asynchronous and active-low.
- Reset state:
  - FSM in IDLE, nibble index 0, carry register 0.
  - s=0, co=0, ovf=0, out_valid=0.
  - in_ready=1 once the state is IDLE.
- FSM states: IDLE → RUN → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b, ci and sub into operand registers, clear the index, and move to RUN.
- RUN, at nibble index k:
  - Drive the slice with a[4k+3:4k] and b[4k+3:4k].
  - Slice carry input: ci for k=0; carry_reg ^ sub for k>0. The slice applies XOR with sub internally, so this gives true two's-complement chaining.
  - Write the slice sum into s[4k+3:4k] and its carry-out into carry_reg.
  - At k=NIBBLES−1:
    - co ← slice carry-out.
    - ovf ← (a[W−1] == (b[W−1]^sub)) && (sum[3] != a[W−1]).
    - Move to DONE.
- DONE:
  - out_valid=1.
  - s, co and ovf are stable and held.
  - On out_ready, return to IDLE. out_valid drops the next cycle.
- in_valid outside IDLE is ignored, and operands are not sampled. in_ready=0 makes this visible to the producer.
- Operand changes on a, b, ci or sub after acceptance do not affect the operation in flight.
- Width rules:
  - All sums are computed modulo 2^W.
  - co is the carry out of bit W−1.
  - ci in sub mode is treated as an extra borrow.
- Reset mid-operation (RUN or DONE) aborts immediately. All outputs take their reset values, and a pending result is discarded.
- s is not cleared between operations. Its value is only meaningful while out_valid=1.

## Timing
- Accept edge = cycle 0, the edge where in_valid && in_ready.
- Nibble k is processed in cycle k+1.
- out_valid rises after the edge ending cycle NIBBLES: NIBBLES cycles after accept, 4 cycles at the default.
- Throughput: one operation per NIBBLES+2 cycles with out_ready held high. The earliest next accept is the cycle after out_valid falls.
- Back-pressure: out_valid and the result hold for any number of cycles while out_ready=0.
- The slice path is combinational within one cycle: register → slice → register.

## Test plan
- Add, default NIBBLES: a=0x1234, b=0x0FFF, ci=0, sub=0 → s=0x2233, co=0, ovf=0; out_valid rises exactly 4 cycles after accept.
- Carry chain and wrap-around:
  - 0xFFFF+0x0001, ci=0 → s=0x0000, co=1, ovf=0.
  - 0x7FFF+0x0001 → s=0x8000, co=0, ovf=1.
- Subtract:
  - 0x0005−0x0007, ci=0 → s=0xFFFE, co=0, ovf=0.
  - 0x8000−0x0001 → s=0x7FFF, co=1, ovf=1.
  - 0x0010−0x0001, ci=1 → s=0x000E, co=1.
- Handshake:
  - Hold out_ready=0 for 3 cycles in DONE → s, co, ovf and out_valid stay constant.
  - Pulse in_valid with new operands during RUN → ignored, and the result matches the first operands.
- Reset mid-RUN: drop rst_n asynchronously at cycle 2 → out_valid=0, s=0, co=0, ovf=0, in_ready=1 after release. A following 0x0001+0x0001 → s=0x0002.
- NIBBLES=2: 0xFF+0x01, sub=0 → s=0x00, co=1, latency 2 cycles.
